// File: rtl/sram_test_sequencer.sv
// Memory self-test sequencer: fills DEPTH words with a seeded pattern, reads them back
// through a READ_LAT-deep compare pipeline and reports error count and first failing address.
module sram_test_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 11,
    parameter int DEPTH    = 128,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W:0]   err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_TURN  = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST_ADDR  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(READ_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [ADDR_W:0] ERR_ONE  = (ADDR_W + 1)'(1);

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] ax;
        ax = DATA_W'(a);
        case (m)
            2'd0:    pattern = s - ax;
            2'd1:    pattern = s + ax;
            2'd2:    pattern = a[0] ? ~s : s;
            default: pattern = s ^ ax;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;

    logic [READ_LAT-1:0]             pv_q, pv_d;
    logic [READ_LAT-1:0][DATA_W-1:0] pe_q, pe_d;
    logic [READ_LAT-1:0][ADDR_W-1:0] pa_q, pa_d;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] addr_pat;
    logic              mismatch;

    // The counter doubles as the address; termination is by count so DEPTH==2^ADDR_W wraps cleanly.
    assign addr     = cnt_q[ADDR_W-1:0];
    assign addr_pat = pattern(mode_q, seed_q, addr);
    assign mismatch = pv_q[READ_LAT-1] && (mem_rdata_i != pe_q[READ_LAT-1]);

    genvar gi;
    generate
        for (gi = 0; gi < READ_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pv_d[gi] = (state_q == S_READ);
                assign pe_d[gi] = addr_pat;
                assign pa_d[gi] = addr;
            end else begin : g_tail
                assign pv_d[gi] = pv_q[gi-1];
                assign pe_d[gi] = pe_q[gi-1];
                assign pa_d[gi] = pa_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            pv_q    <= '0;
            pe_q    <= '0;
            pa_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pv_q    <= pv_d;
            pe_q    <= pe_d;
            pa_q    <= pa_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        err_d   = err_q;
        ferr_d  = ferr_q;

        if (mismatch) begin
            if (err_q != '1) err_d = err_q + ERR_ONE;
            if (err_q == '0) ferr_d = pa_q[READ_LAT-1];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    seed_d  = seed_i;
                    err_d   = '0;
                    ferr_d  = '0;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_TURN: begin
                cnt_d   = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_we_o         = (state_q == S_WRITE);
        mem_re_o         = (state_q == S_READ);
        mem_addr_o       = (mem_we_o || mem_re_o) ? addr : '0;
        mem_wdata_o      = mem_we_o ? addr_pat : '0;
        busy_o           = (state_q == S_WRITE) || (state_q == S_TURN) ||
                           (state_q == S_READ)  || (state_q == S_DRAIN);
        done_o           = (state_q == S_DONE);
        pass_o           = done_o && (err_q == '0);
        err_count_o      = err_q;
        first_err_addr_o = ferr_q;
        state_o          = state_q;
    end

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Directed bench: two sequencers (read latency 1 and 3) share stimulus, each with its own
// behavioural SRAM and optional stuck-bit fault; write traffic of the first is scoreboarded.
module tb_sram_test_sequencer;

    localparam int DEPTH  = 128;
    localparam int EXP_N1 = 2 * DEPTH + 1 + 1;  // edges after the start edge until done (latency 1)
    localparam int EXP_N3 = 2 * DEPTH + 1 + 3;  // same, latency 3

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [15:0] seed  = 16'd0;
    bit          fault = 1'b0;

    logic [10:0] addr1, addr3, ferr1, ferr3;
    logic [15:0] wdata1, wdata3, rdata1, rdata3;
    logic        we1, we3, re1, re3, busy1, busy3, done1, done3, pass1, pass3;
    logic [11:0] err1, err3;
    logic [2:0]  state1, state3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clock = ~clock;

    sram_test_sequencer #(.DATA_W(16), .ADDR_W(11), .DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
        .clock(clock), .rst(rst), .start_i(start), .mode_i(mode), .seed_i(seed),
        .mem_addr_o(addr1), .mem_wdata_o(wdata1), .mem_we_o(we1), .mem_re_o(re1),
        .mem_rdata_i(rdata1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_count_o(err1), .first_err_addr_o(ferr1), .state_o(state1)
    );

    sram_test_sequencer #(.DATA_W(16), .ADDR_W(11), .DEPTH(DEPTH), .READ_LAT(3)) u_dut3 (
        .clock(clock), .rst(rst), .start_i(start), .mode_i(mode), .seed_i(seed),
        .mem_addr_o(addr3), .mem_wdata_o(wdata3), .mem_we_o(we3), .mem_re_o(re3),
        .mem_rdata_i(rdata3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
        .err_count_o(err3), .first_err_addr_o(ferr3), .state_o(state3)
    );

    function automatic logic [15:0] flip(input logic [10:0] a);
        return (fault && (a == 11'd5 || a == 11'd77)) ? 16'h0001 : 16'h0000;
    endfunction

    // Behavioural SRAMs: registered writes, READ_LAT-cycle read pipe.
    logic [15:0] mem1 [2048];
    logic [15:0] mem3 [2048];
    logic [15:0] rp1;
    logic [15:0] rp3 [3];
    assign rdata1 = rp1;
    assign rdata3 = rp3[2];

    always @(posedge clock) begin
        if (we1) mem1[addr1] <= wdata1 ^ flip(addr1);
        if (re1) rp1 <= mem1[addr1];
        if (we3) mem3[addr3] <= wdata3 ^ flip(addr3);
        rp3[0] <= mem3[addr3];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    function automatic logic [15:0] pat(input int m, input logic [15:0] s, input int a);
        case (m)
            0:       return s - 16'(a);
            1:       return s + 16'(a);
            2:       return a[0] ? ~s : s;
            default: return s ^ 16'(a);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!rst) begin
            if (we1 || re1) chk("we_re_exclusive", {31'd0, we1 & re1}, 32'd0);
            if (we1) begin
                chk("wq_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {21'd0, addr1}, {21'd0, e.addr});
                    chk("wr_data", {16'd0, wdata1}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic push_run(input int m, input logic [15:0] s);
        for (int a = 0; a < DEPTH; a++) begin
            wr_t e;
            e.addr = 11'(a);
            e.data = pat(m, s, a);
            exp_q.push_back(e);
        end
    endtask

    // Launches a run and waits (bounded) for both instances to reach DONE.
    task automatic run(input int m, input logic [15:0] s, input bit poke,
                       output int n1, output int n3);
        push_run(m, s);
        @(negedge clock);
        mode  = 2'(m);
        seed  = s;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("start_state1", {29'd0, state1}, 32'd1);
        chk("start_state3", {29'd0, state3}, 32'd1);
        chk("start_done1", {31'd0, done1}, 32'd0);
        chk("start_err1", {20'd0, err1}, 32'd0);
        chk("start_ferr1", {21'd0, ferr1}, 32'd0);
        n1 = -1;
        n3 = -1;
        for (int n = 0; n < 1000 && (n1 < 0 || n3 < 0); n++) begin
            start = poke && (state1 == 3'd3) && n[1];
            @(posedge clock);
            #1;
            if (done1 && n1 < 0) n1 = n + 1;
            if (done3 && n3 < 0) n3 = n + 1;
        end
        start = 1'b0;
        chk("wq_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n3;
        bit found, seen_done;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", {29'd0, state1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_pass", {31'd0, pass1}, 32'd0);
        chk("rst_err", {20'd0, err1}, 32'd0);
        chk("rst_we", {31'd0, we1}, 32'd0);
        chk("rst_re", {31'd0, re1}, 32'd0);
        chk("rst_addr", {21'd0, addr1}, 32'd0);
        @(negedge clock);
        rst = 1'b0;

        // Descending pattern, ideal memory.
        run(0, 16'd127, 1'b0, n1, n3);
        $display("run mode0 seed=007f: n1=%0d n3=%0d err1=%0d err3=%0d", n1, n3, err1, err3);
        chk("t1_lat1", n1, EXP_N1);
        chk("t1_lat3", n3, EXP_N3);
        chk("t1_pass1", {31'd0, pass1}, 32'd1);
        chk("t1_pass3", {31'd0, pass3}, 32'd1);
        chk("t1_err1", {20'd0, err1}, 32'd0);
        chk("t1_mem0", {16'd0, mem1[0]}, 32'h007F);
        chk("t1_mem64", {16'd0, mem1[64]}, 32'h003F);
        chk("t1_mem127", {16'd0, mem1[127]}, 32'h0000);

        // Bit-0 faults at addresses 5 and 77.
        fault = 1'b1;
        run(0, 16'd127, 1'b0, n1, n3);
        $display("run mode0 fault: err1=%0d ferr1=%0d err3=%0d ferr3=%0d", err1, ferr1, err3, ferr3);
        chk("t2_err1", {20'd0, err1}, 32'd2);
        chk("t2_ferr1", {21'd0, ferr1}, 32'd5);
        chk("t2_pass1", {31'd0, pass1}, 32'd0);
        chk("t2_done1", {31'd0, done1}, 32'd1);
        chk("t2_err3", {20'd0, err3}, 32'd2);
        chk("t2_ferr3", {21'd0, ferr3}, 32'd5);
        chk("t2_pass3", {31'd0, pass3}, 32'd0);

        // Restart from DONE (err must clear), checkerboard.
        fault = 1'b0;
        run(2, 16'hAAAA, 1'b0, n1, n3);
        $display("run mode2 seed=aaaa: n3=%0d err3=%0d", n3, err3);
        chk("t3_lat3", n3, EXP_N3);
        chk("t3_pass3", {31'd0, pass3}, 32'd1);
        chk("t3_err3", {20'd0, err3}, 32'd0);
        chk("t3_mem0", {16'd0, mem3[0]}, 32'hAAAA);
        chk("t3_mem1", {16'd0, mem3[1]}, 32'h5555);
        chk("t3_pass1", {31'd0, pass1}, 32'd1);

        // Ascending with data wrap; start pulsed during READ must be ignored.
        run(1, 16'hFFF0, 1'b1, n1, n3);
        $display("run mode1 seed=fff0 poke: n1=%0d err1=%0d", n1, err1);
        chk("t4_lat1", n1, EXP_N1);
        chk("t4_lat3", n3, EXP_N3);
        chk("t4_mem15", {16'd0, mem1[15]}, 32'hFFFF);
        chk("t4_mem16", {16'd0, mem1[16]}, 32'h0000);
        chk("t4_pass1", {31'd0, pass1}, 32'd1);
        chk("t4_pass3", {31'd0, pass3}, 32'd1);

        // Reset in the middle of the write phase.
        push_run(3, 16'h1234);
        @(negedge clock);
        mode  = 2'd3;
        seed  = 16'h1234;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (we1 && addr1 == 11'd40) found = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        chk("t5_reached40", {31'd0, found}, 32'd1);
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1;
        $display("reset at addr40: state1=%0d we1=%0d addr1=%0d", state1, we1, addr1);
        chk("t5_state1", {29'd0, state1}, 32'd0);
        chk("t5_state3", {29'd0, state3}, 32'd0);
        chk("t5_we1", {31'd0, we1}, 32'd0);
        chk("t5_addr1", {21'd0, addr1}, 32'd0);
        chk("t5_busy1", {31'd0, busy1}, 32'd0);
        @(negedge clock);
        rst = 1'b0;
        exp_q.delete();
        seen_done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clock);
            #1;
            if (done1 || done3) seen_done = 1'b1;
        end
        chk("t5_no_done", {31'd0, seen_done}, 32'd0);

        run(3, 16'h1234, 1'b0, n1, n3);
        $display("run mode3 seed=1234 after reset: n1=%0d err1=%0d err3=%0d", n1, err1, err3);
        chk("t5_lat1", n1, EXP_N1);
        chk("t5_pass1", {31'd0, pass1}, 32'd1);
        chk("t5_pass3", {31'd0, pass3}, 32'd1);
        chk("t5_mem3", {16'd0, mem1[3]}, 32'h1237);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_test_sequencer.md
Name: sram_test_sequencer

Overview:
Parametrised memory self-test sequencer that drives the MAR/MDR/SRAM datapath.
- Writes a selectable data pattern to DEPTH consecutive addresses.
- Reads the same addresses back and compares each word against the expected value.
- Reports pass/fail, error count and first failing address.
- Sits between board-level controls (switches/keys, divided clock) and the memory interface. It is the generalised replacement for fixed-pattern fill/readback control.

Parameters:
DATA_W, 16, memory word width.
ADDR_W, 11, memory address width.
DEPTH, 128, number of words tested from address 0. Legal range is 2 ≤ DEPTH ≤ 2^ADDR_W.
READ_LAT, 1, memory read latency in cycles. Legal range is 1..4.

Ports:
clock  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  level; begins a run when sampled high in IDLE or DONE
mode  in  2  pattern select, latched at run start
seed  in  DATA_W  pattern seed, latched at run start
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_we  out  1  write enable; memory writes at the edge ending the cycle
mem_re  out  1  read enable
mem_rdata  in  DATA_W  read data; valid READ_LAT cycles after the mem_re cycle
busy  out  1  high in WRITE/TURN/READ/DRAIN
done  out  1  high in DONE
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  ADDR_W+1  number of mismatching words; saturates at all-ones
first_err_addr  out  ADDR_W  address of first mismatch in the run
state_out  out  3  current state encoding, for LED debug

Behaviour:
- Reset (any state, mid-run included): takes effect on the next edge.
  - State goes to IDLE.
  - mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
  - busy=0, done=0, pass=0, err_count=0, first_err_addr=0.
  - Compare pipeline is flushed; no pending compare survives reset.
- State encodings: IDLE=0, WRITE=1, TURN=2, READ=3, DRAIN=4, DONE=5. Unused codes go to IDLE.
- Expected data for address a, arithmetic mod 2^DATA_W:
  - mode 0: seed − a (descending)
  - mode 1: seed + a (ascending)
  - mode 2: a[0] ? ~seed : seed (checkerboard)
  - mode 3: seed XOR zero-extended a
- IDLE/DONE with start=1:
  - Latch mode and seed; clear err_count and first_err_addr; clear done; addr=0.
  - Go to WRITE.
  - start is ignored in all busy states.
  - DONE holds until start or rst.
- WRITE: mem_we=1, mem_addr=addr, mem_wdata=pattern(addr).
  - addr increments every cycle, DEPTH cycles total.
  - After the cycle with addr==DEPTH−1, go to TURN.
- TURN: one cycle with mem_we=0 and mem_re=0. addr=0. Then go to READ.
- READ: mem_re=1, mem_addr=addr, DEPTH cycles.
  - The expected value and address enter a READ_LAT-deep valid/expected/address shift pipeline.
  - After addr==DEPTH−1, go to DRAIN.
- DRAIN: mem_re=0 for READ_LAT cycles while the pipeline empties. Then go to DONE.
- Compare: in each cycle where the pipeline output is valid, compare mem_rdata with the expected value.
  - On mismatch: err_count increments (saturating).
  - If this is the first mismatch of the run, first_err_addr takes the piped address.
- Latency: start sampled at edge T → first WRITE cycle T+1 → done=1 at cycle T+2·DEPTH+2+READ_LAT.
  - DEPTH=128, READ_LAT=1: done at T+259.
- Outputs are decoded from registered state/addr. mem_we and mem_re are never both high.
- Address wrap: when DEPTH==2^ADDR_W, addr wraps to 0 after the last access. The terminal check uses a count, not addr overflow.

Test Plan:
1. Mode 0, seed=127, DEPTH=128, READ_LAT=1, ideal memory → writes addr0=127 … addr127=0; done at T+259; pass=1; err_count=0.
2. Fault model inverts stored bit 0 at addr 5 and addr 77 → err_count=2, first_err_addr=5, pass=0.
3. READ_LAT=3, mode 2, seed=16'hAAAA → addr0=AAAA, addr1=5555; all compares align; pass=1; done at T+261.
4. Mode 1, seed=16'hFFF0 → addr15=FFFF, addr16=0000 (wrap); pass=1.
5. rst asserted in WRITE at addr 40 → next cycle state=IDLE, mem_we=0, mem_addr=0; done never rises; restart with start gives a clean pass.
6. start toggled during READ is ignored. start held high in DONE restarts the run: err_count clears and done drops the next cycle.
